round_controller: RTL and testbench

- Game-round sequencer for the countdown timer datapath: the rate divider, the 8-bit down-counting timer and the hex display.
- Loads the timer with a per-round time budget and gates the 1 Hz tick into the timer enable.
- Handles start, pause and resume, advances rounds on player success, and declares the game won or lost.
- Sits between the switch/key inputs, the rate divider and the timer.

---
 rtl/round_controller.sv | 192 +++++++++++++++++++
 tb/tb_round_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// -----------------------------------------------------------------------------
// round_controller
// Game-round sequencer for the countdown timer datapath. It loads the timer
// with a per-round time budget, gates the 1 Hz tick into the timer enable,
// handles start / pause / resume, advances rounds on player success and
// declares the game won or lost.
//
// Ports:
//   Clock          in   system clock
//   Reset          in   asynchronous, active-low reset
//   Start          in   level, rising edge starts / restarts a game
//   Pause          in   level, each rising edge toggles pause while playing
//   Tick           in   one-cycle pulse from the rate divider
//   Success        in   one-cycle pulse, player cleared the current round
//   TimerValue     in   current timer count (8 bit)
//   TimerLoad      out  one-cycle load strobe to the timer
//   TimerLoadValue out  budget to load, held after the strobe
//   TimerEnable    out  decrement enable to the timer (Tick gated by RUN)
//   Round          out  current round, 1-based, 0 in IDLE
//   Warning        out  registered low-time indicator
//   State          out  encoded FSM state for debug LEDs
//   GameWon        out  level, game won
//   GameLost       out  level, game lost
// -----------------------------------------------------------------------------
module round_controller #(
    parameter int ROUNDS     = 3,
    parameter int ROUND_TIME = 120,
    parameter int TIME_STEP  = 20,
    parameter int MIN_TIME   = 30,
    parameter int WARN_TIME  = 10
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic       Pause,
    input  logic       Tick,
    input  logic       Success,
    input  logic [7:0] TimerValue,
    output logic       TimerLoad,
    output logic [7:0] TimerLoadValue,
    output logic       TimerEnable,
    output logic [3:0] Round,
    output logic       Warning,
    output logic [2:0] State,
    output logic       GameWon,
    output logic       GameLost
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RUN       = 3'd2,
        ST_PAUSED    = 3'd3,
        ST_ROUND_END = 3'd4,
        ST_WON       = 3'd5,
        ST_LOST      = 3'd6
    } state_t;

    localparam logic signed [11:0] ROUND_TIME_C = 12'(ROUND_TIME);
    localparam logic signed [11:0] TIME_STEP_C  = 12'(TIME_STEP);
    localparam logic signed [11:0] MIN_TIME_C   = 12'(MIN_TIME);
    localparam logic [3:0]         ROUNDS_C     = 4'(ROUNDS);
    localparam logic [7:0]         WARN_TIME_C  = 8'(WARN_TIME);

    // Budget for a round: ROUND_TIME - (round-1)*TIME_STEP, floored at MIN_TIME.
    // Evaluated as 12-bit signed so a budget that goes negative still clamps.
    function automatic logic [7:0] budget_f(input logic [3:0] round);
        logic signed [11:0] round_s;
        logic signed [11:0] time_s;
        round_s = $signed({8'd0, round}) - 12'sd1;
        time_s  = ROUND_TIME_C - (TIME_STEP_C * round_s);
        if (time_s < MIN_TIME_C) begin
            budget_f = MIN_TIME_C[7:0];
        end else begin
            budget_f = time_s[7:0];
        end
    endfunction

    state_t     state_r;
    state_t     state_next_s;
    logic [3:0] round_r;
    logic [3:0] round_next_s;
    logic [7:0] load_value_r;
    logic [7:0] load_next_s;
    logic       warning_r;
    logic       warning_next_s;
    logic       start_prev_r;
    logic       pause_prev_r;
    logic       start_edge_s;
    logic       pause_edge_s;

    assign start_edge_s = Start & ~start_prev_r;
    assign pause_edge_s = Pause & ~pause_prev_r;

    // State, round, budget, warning and edge-detect registers.
    // Edge-detect history resets high so a level held across reset is no edge.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r      <= ST_IDLE;
            round_r      <= 4'd0;
            load_value_r <= 8'd0;
            warning_r    <= 1'b0;
            start_prev_r <= 1'b1;
            pause_prev_r <= 1'b1;
        end else begin
            state_r      <= state_next_s;
            round_r      <= round_next_s;
            load_value_r <= load_next_s;
            warning_r    <= warning_next_s;
            start_prev_r <= Start;
            pause_prev_r <= Pause;
        end
    end

    // Next-state logic; the budget is latched on entry to LOAD so it is
    // valid during the strobe and held afterwards.
    always_comb begin
        state_next_s = state_r;
        round_next_s = round_r;
        load_next_s  = load_value_r;
        case (state_r)
            ST_IDLE, ST_WON, ST_LOST: begin
                if (start_edge_s) begin
                    state_next_s = ST_LOAD;
                    round_next_s = 4'd1;
                    load_next_s  = budget_f(4'd1);
                end else begin
                    state_next_s = state_r;
                end
            end
            ST_LOAD: begin
                state_next_s = ST_RUN;
            end
            ST_RUN: begin
                // Timeout beats success, success beats pause.
                if (TimerValue == 8'd0) begin
                    state_next_s = ST_LOST;
                end else if (Success) begin
                    state_next_s = ST_ROUND_END;
                end else if (pause_edge_s) begin
                    state_next_s = ST_PAUSED;
                end else begin
                    state_next_s = ST_RUN;
                end
            end
            ST_PAUSED: begin
                if (pause_edge_s) begin
                    state_next_s = ST_RUN;
                end else begin
                    state_next_s = ST_PAUSED;
                end
            end
            ST_ROUND_END: begin
                if (round_r == ROUNDS_C) begin
                    state_next_s = ST_WON;
                end else begin
                    state_next_s = ST_LOAD;
                    round_next_s = round_r + 4'd1;
                    load_next_s  = budget_f(round_r + 4'd1);
                end
            end
            default: begin
                state_next_s = ST_IDLE;
                round_next_s = 4'd0;
                load_next_s  = 8'd0;
            end
        endcase
    end

    // Low-time indicator, only meaningful while a round is in play.
    always_comb begin
        warning_next_s = 1'b0;
        if (((state_r == ST_RUN) || (state_r == ST_PAUSED)) &&
            (TimerValue != 8'd0) && (TimerValue <= WARN_TIME_C)) begin
            warning_next_s = 1'b1;
        end else begin
            warning_next_s = 1'b0;
        end
    end

    // Outputs are decoded from registers only; TimerEnable additionally
    // passes Tick straight through so the timer sees it with no latency.
    assign TimerLoad      = (state_r == ST_LOAD);
    assign TimerLoadValue = load_value_r;
    assign TimerEnable    = Tick & (state_r == ST_RUN);
    assign Round          = round_r;
    assign Warning        = warning_r;
    assign State          = state_r;
    assign GameWon        = (state_r == ST_WON);
    assign GameLost       = (state_r == ST_LOST);

endmodule

// File: tb/tb_round_controller.sv
module tb_round_controller;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic       Pause;
    logic       Tick;
    logic       Success;
    logic [7:0] TimerValue;
    logic       TimerLoad;
    logic [7:0] TimerLoadValue;
    logic       TimerEnable;
    logic [3:0] Round;
    logic       Warning;
    logic [2:0] State;
    logic       GameWon;
    logic       GameLost;

    logic       start6;
    logic       success6;
    logic       load6;
    logic [7:0] load_value6;
    logic       enable6;
    logic [3:0] round6;
    logic       warning6;
    logic [2:0] state6;
    logic       won6;
    logic       lost6;

    int tests_run    = 0;
    int tests_failed = 0;
    int en_cnt       = 0;
    int en_base;

    round_controller u_dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Pause(Pause),
        .Tick(Tick), .Success(Success), .TimerValue(TimerValue),
        .TimerLoad(TimerLoad), .TimerLoadValue(TimerLoadValue),
        .TimerEnable(TimerEnable), .Round(Round), .Warning(Warning),
        .State(State), .GameWon(GameWon), .GameLost(GameLost)
    );

    round_controller #(.ROUNDS(6)) u_dut6 (
        .Clock(Clock), .Reset(Reset), .Start(start6), .Pause(1'b0),
        .Tick(1'b0), .Success(success6), .TimerValue(8'd50),
        .TimerLoad(load6), .TimerLoadValue(load_value6),
        .TimerEnable(enable6), .Round(round6), .Warning(warning6),
        .State(state6), .GameWon(won6), .GameLost(lost6)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    always @(posedge Clock) begin
        if (TimerEnable === 1'b1) en_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Pulse Success in RUN, confirm ROUND_END, then step to the following state.
    task automatic round_success();
        Success = 1'b1;
        @(negedge Clock);
        Success = 1'b0;
        #1 check("round_end_state", 32'(State), 32'd4);
        @(negedge Clock);
        #1;
    endtask

    logic [7:0] exp6 [6] = '{8'd120, 8'd100, 8'd80, 8'd60, 8'd40, 8'd30};

    initial begin
        Reset = 1'b0; Start = 1'b1; Pause = 1'b0; Tick = 1'b0; Success = 1'b0;
        TimerValue = 8'd50; start6 = 1'b0; success6 = 1'b0;
        #1;
        check("rst_state", 32'(State), 32'd0);
        check("rst_round", 32'(Round), 32'd0);
        check("rst_load", 32'(TimerLoad), 32'd0);
        check("rst_load_value", 32'(TimerLoadValue), 32'd0);
        check("rst_flags", {29'd0, GameWon, GameLost, Warning}, 32'd0);
        repeat (2) @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock); #1;
        // Start held high across reset release: no edge.
        check("held_start_state", 32'(State), 32'd0);
        check("held_start_load", 32'(TimerLoad), 32'd0);
        check("held_start_round", 32'(Round), 32'd0);
        Start = 1'b0;
        @(negedge Clock); #1;
        Start = 1'b1;
        @(negedge Clock); #1;
        check("load1_state", 32'(State), 32'd1);
        check("load1_strobe", 32'(TimerLoad), 32'd1);
        check("load1_value", 32'(TimerLoadValue), 32'd120);
        check("load1_round", 32'(Round), 32'd1);
        Start = 1'b0;
        @(negedge Clock); #1;
        check("run_state", 32'(State), 32'd2);
        check("run_strobe_off", 32'(TimerLoad), 32'd0);
        check("run_value_held", 32'(TimerLoadValue), 32'd120);

        // Ticks pass straight through in RUN.
        en_base = en_cnt;
        for (int i = 0; i < 5; i++) begin
            Tick = 1'b1;
            #1 check("tick_en", 32'(TimerEnable), 32'd1);
            @(negedge Clock); #1;
            Tick = 1'b0;
            #1 check("tick_gap", 32'(TimerEnable), 32'd0);
            @(negedge Clock); #1;
        end
        check("tick_count", 32'(en_cnt - en_base), 32'd5);

        // Tick in the RUN->PAUSED cycle still passes.
        Pause = 1'b1; Tick = 1'b1;
        #1 check("tick_at_pause", 32'(TimerEnable), 32'd1);
        @(negedge Clock); #1;
        Tick = 1'b0;
        check("paused_state", 32'(State), 32'd3);
        for (int i = 0; i < 3; i++) begin
            Tick = 1'b1;
            #1 check("paused_tick", 32'(TimerEnable), 32'd0);
            @(negedge Clock); #1;
            Tick = 1'b0;
        end
        Success = 1'b1;
        @(negedge Clock); #1;
        Success = 1'b0;
        check("paused_success_ignored", 32'(State), 32'd3);
        Pause = 1'b0;
        @(negedge Clock); #1;
        Pause = 1'b1;
        @(negedge Clock); #1;
        check("resume_state", 32'(State), 32'd2);
        Pause = 1'b0; Tick = 1'b1;
        #1 check("resume_tick", 32'(TimerEnable), 32'd1);
        @(negedge Clock); #1;
        Tick = 1'b0;

        // Rounds 1 and 2 cleared, round 3 cleared wins.
        round_success();
        check("load2_strobe", 32'(TimerLoad), 32'd1);
        check("load2_value", 32'(TimerLoadValue), 32'd100);
        check("load2_round", 32'(Round), 32'd2);
        @(negedge Clock); #1;
        round_success();
        check("load3_value", 32'(TimerLoadValue), 32'd80);
        check("load3_round", 32'(Round), 32'd3);
        @(negedge Clock); #1;
        round_success();
        Tick = 1'b1;
        #1;
        check("won_state", 32'(State), 32'd5);
        check("won_flag", 32'(GameWon), 32'd1);
        check("won_enable", 32'(TimerEnable), 32'd0);
        Tick = 1'b0;

        // Restart from WON.
        Start = 1'b1;
        @(negedge Clock); #1;
        check("restart_state", 32'(State), 32'd1);
        check("restart_won_clr", 32'(GameWon), 32'd0);
        check("restart_round", 32'(Round), 32'd1);
        Start = 1'b0;
        @(negedge Clock); #1;

        // Timeout beats Success.
        TimerValue = 8'd0; Success = 1'b1;
        @(negedge Clock); #1;
        Success = 1'b0; TimerValue = 8'd50;
        check("lost_state", 32'(State), 32'd6);
        check("lost_flag", 32'(GameLost), 32'd1);
        check("lost_round", 32'(Round), 32'd1);
        Start = 1'b1;
        @(negedge Clock); #1;
        check("lost_restart_state", 32'(State), 32'd1);
        check("lost_restart_clr", 32'(GameLost), 32'd0);
        check("lost_restart_value", 32'(TimerLoadValue), 32'd120);
        check("lost_restart_round", 32'(Round), 32'd1);
        Start = 1'b0;
        @(negedge Clock); #1;

        // Warning threshold and timeout.
        TimerValue = 8'd11;
        @(negedge Clock); #1;
        check("warn_11", 32'(Warning), 32'd0);
        TimerValue = 8'd10;
        @(negedge Clock); #1;
        check("warn_10", 32'(Warning), 32'd1);
        TimerValue = 8'd0;
        @(negedge Clock); #1;
        check("warn_lost_state", 32'(State), 32'd6);
        check("warn_lost_clr", 32'(Warning), 32'd0);

        // Back to RUN with Warning set, then asynchronous reset mid-cycle.
        TimerValue = 8'd5; Start = 1'b1;
        @(negedge Clock); #1;
        Start = 1'b0;
        @(negedge Clock); #1;
        @(negedge Clock); #1;
        check("pre_rst_warn", 32'(Warning), 32'd1);
        Tick = 1'b1;
        Reset = 1'b0;
        #1;
        check("async_rst_state", 32'(State), 32'd0);
        check("async_rst_round", 32'(Round), 32'd0);
        check("async_rst_value", 32'(TimerLoadValue), 32'd0);
        check("async_rst_warn", 32'(Warning), 32'd0);
        check("async_rst_enable", 32'(TimerEnable), 32'd0);
        Tick = 1'b0; TimerValue = 8'd50;
        @(negedge Clock);
        Reset = 1'b1;
        @(negedge Clock); #1;

        // Six-round instance: budget clamps at MIN_TIME in round 6.
        start6 = 1'b1;
        @(negedge Clock); #1;
        start6 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("r6_strobe", 32'(load6), 32'd1);
            check("r6_value", 32'(load_value6), 32'(exp6[i]));
            check("r6_round", 32'(round6), 32'(i + 1));
            @(negedge Clock); #1;
            success6 = 1'b1;
            @(negedge Clock); #1;
            success6 = 1'b0;
            @(negedge Clock); #1;
        end
        check("r6_won_state", 32'(state6), 32'd5);
        check("r6_won_flag", 32'(won6), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
